lab_buffer_scheduler: RTL

LAB_BUFFER_SCHEDULER -- requirements
Module: lab_buffer_scheduler

---
 rtl/surf_lab_pkg.sv | 15 +
 rtl/lab_buf_slot.sv | 81 ++++++++
 rtl/lab_buffer_scheduler.sv | 98 +++++++++
 3 files changed

// File: rtl/surf_lab_pkg.sv
// Shared definitions for the LAB buffer scheduler: defaults, widths and the per-buffer state enum.
package surf_lab_pkg;

    localparam int unsigned NBUF_DEFAULT        = 4;
    localparam int unsigned DIG_TIMEOUT_DEFAULT = 4095;
    localparam int unsigned ID_W                = 32;
    localparam int unsigned DROP_W              = 16;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        DIG   = 2'd1,
        READY = 2'd2
    } buf_state_e;

endpackage

// File: rtl/lab_buf_slot.sv
// One LAB sample buffer: state, captured event ID, digitize timeout counter and timeout flag.
// Next-state values are exported so the scheduler can register its read-side outputs in the same cycle.
module lab_buf_slot
    import surf_lab_pkg::*;
#(
    parameter int unsigned DIG_TIMEOUT = DIG_TIMEOUT_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            i_alloc,
    input  logic [ID_W-1:0] i_id,
    input  logic            i_done,
    input  logic            i_release,
    output buf_state_e      o_state_nxt_c,
    output logic [ID_W-1:0] o_id_nxt_c,
    output logic            o_tmo_nxt_c,
    output logic            o_tmo_evt_c
);

    localparam int unsigned TCNT_W = $clog2(DIG_TIMEOUT + 1);

    buf_state_e        r_state;
    logic [ID_W-1:0]   r_id;
    logic [TCNT_W-1:0] r_tcnt;
    logic              r_tmo;
    logic [TCNT_W-1:0] w_tcnt_nxt;

    // Buffer lifecycle; a done pulse in the same cycle as the timeout wins.
    always_comb begin
        o_state_nxt_c = r_state;
        o_id_nxt_c    = r_id;
        o_tmo_nxt_c   = r_tmo;
        o_tmo_evt_c   = 1'b0;
        w_tcnt_nxt    = r_tcnt;
        case (r_state)
            FREE: begin
                if (i_alloc) begin
                    o_state_nxt_c = DIG;
                    o_id_nxt_c    = i_id;
                    o_tmo_nxt_c   = 1'b0;
                    w_tcnt_nxt    = '0;
                end
            end
            DIG: begin
                if (i_done) begin
                    o_state_nxt_c = READY;
                end else if (r_tcnt == TCNT_W'(DIG_TIMEOUT - 1)) begin
                    o_state_nxt_c = READY;
                    o_tmo_nxt_c   = 1'b1;
                    o_tmo_evt_c   = 1'b1;
                end else begin
                    w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                end
            end
            READY: begin
                w_tcnt_nxt = '0;
                if (i_release) begin
                    o_state_nxt_c = FREE;
                end
            end
            default: begin
                o_state_nxt_c = FREE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= FREE;
            r_id    <= '0;
            r_tcnt  <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= o_state_nxt_c;
            r_id    <= o_id_nxt_c;
            r_tcnt  <= w_tcnt_nxt;
            r_tmo   <= o_tmo_nxt_c;
        end
    end

endmodule

// File: rtl/lab_buffer_scheduler.sv
// Ring scheduler for NBUF LAB sample buffers: allocates on trigger, tracks digitize completion,
// and presents buffers for readout strictly in allocation order.
module lab_buffer_scheduler
    import surf_lab_pkg::*;
#(
    parameter int unsigned NBUF        = NBUF_DEFAULT,
    parameter int unsigned DIG_TIMEOUT = DIG_TIMEOUT_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      trig_i,
    input  logic [ID_W-1:0]           trig_id_i,
    output logic [NBUF-1:0]           dig_o,
    input  logic [NBUF-1:0]           dig_done_i,
    output logic                      rd_valid_o,
    output logic [$clog2(NBUF)-1:0]   rd_buf_o,
    output logic [ID_W-1:0]           rd_id_o,
    output logic                      rd_timeout_o,
    input  logic                      rd_release_i,
    output logic                      busy_o,
    output logic [DROP_W-1:0]         drop_cnt_o,
    output logic                      err_o
);

    localparam int unsigned PTR_W = $clog2(NBUF);
    localparam int unsigned CNT_W = $clog2(NBUF + 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_release;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;

    buf_state_e       w_state_nxt [NBUF];
    logic [ID_W-1:0]  w_id_nxt    [NBUF];
    logic [NBUF-1:0]  w_tmo_nxt;
    logic [NBUF-1:0]  w_tmo_evt;

    // Occupancy is judged before any same-cycle release, so a full ring drops the trigger.
    always_comb begin
        w_accept     = trig_i && (r_count != CNT_W'(NBUF));
        w_release    = rd_release_i && rd_valid_o;
        w_count_nxt  = r_count + CNT_W'(w_accept) - CNT_W'(w_release);
        w_rd_ptr_nxt = w_release ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
    end

    for (genvar k = 0; k < NBUF; k++) begin : g_slot
        lab_buf_slot #(
            .DIG_TIMEOUT (DIG_TIMEOUT)
        ) u_slot (
            .clk_i         (clk_i),
            .rst_n_i       (rst_n_i),
            .i_alloc       (w_accept && (r_wr_ptr == PTR_W'(k))),
            .i_id          (trig_id_i),
            .i_done        (dig_done_i[k]),
            .i_release     (w_release && (r_rd_ptr == PTR_W'(k))),
            .o_state_nxt_c (w_state_nxt[k]),
            .o_id_nxt_c    (w_id_nxt[k]),
            .o_tmo_nxt_c   (w_tmo_nxt[k]),
            .o_tmo_evt_c   (w_tmo_evt[k])
        );
    end

    // Read-side outputs are registered from the next head pointer and next slot values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            dig_o        <= '0;
            busy_o       <= 1'b0;
            drop_cnt_o   <= '0;
            err_o        <= 1'b0;
            rd_valid_o   <= 1'b0;
            rd_buf_o     <= '0;
            rd_id_o      <= '0;
            rd_timeout_o <= 1'b0;
        end else begin
            r_wr_ptr     <= w_accept ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_count_nxt;
            dig_o        <= w_accept ? (NBUF'(1) << r_wr_ptr) : '0;
            busy_o       <= (w_count_nxt == CNT_W'(NBUF));
            if (trig_i && !w_accept && (drop_cnt_o != '1)) begin
                drop_cnt_o <= drop_cnt_o + DROP_W'(1);
            end
            err_o        <= err_o | (|w_tmo_evt);
            rd_valid_o   <= (w_state_nxt[w_rd_ptr_nxt] == READY);
            rd_buf_o     <= w_rd_ptr_nxt;
            rd_id_o      <= w_id_nxt[w_rd_ptr_nxt];
            rd_timeout_o <= w_tmo_nxt[w_rd_ptr_nxt];
        end
    end

endmodule
